// File: rtl/output_dp_mem_256b_32b.sv
// ---------------------------------------------------------------------------
// output_dp_mem_256b_32b
//
// Result write-back buffer between the matrix-multiply array (PL) and the
// processor (PS). Full 256-bit result rows arrive over a valid/ready
// handshake. Each row is split into eight 32-bit lanes, and each lane is
// stored in its own bank. The PS reads the buffer through a 32-bit
// BRAM-controller style port. The word address is 8*row + lane, which is the
// same packing the input memory uses.
//
// A three-state FSM (IDLE / COLLECT / DONE) does three jobs:
//   - counts the accepted rows,
//   - throttles the producer through row_ready,
//   - flags completion once ROWS rows are stored.
//
// Optional feature macro: OUTPUT_MEM_PS_WRITE_EN
//   defined   : PS port may write (byte enables we_a, data din_a). If the PS
//               and the PL write the same word in the same cycle, the PL
//               write wins.
//   undefined : we_a / din_a are ignored. Every en_a cycle is a read.
//
// Ports
//   clk           in   1    single clock for PL and PS sides
//   rst_n         in   1    asynchronous active-low reset (control state only)
//   start         in   1    pulse: clear row counter, (re)start collection
//   row_valid     in   1    producer offers a row on row_data
//   row_ready     out  1    buffer accepts a row this cycle (Moore, COLLECT)
//   row_data      in   256  result row, [255:224] = lane 0 ... [31:0] = lane 7
//   busy          out  1    high while collecting
//   done          out  1    high once all ROWS rows are stored
//   rows_written  out  7    rows accepted since the last start (0..ROWS)
//   en_a          in   1    PS port enable
//   we_a          in   4    PS byte write enables (feature macro only)
//   addr_a        in   9    PS word address
//   din_a         in   32   PS write data (feature macro only)
//   dout_a        out  32   PS read data, one cycle latency, read-first
// ---------------------------------------------------------------------------
module output_dp_mem_256b_32b #(
    parameter int ROWS  = 64,
    parameter int LANES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         row_valid,
    output logic         row_ready,
    input  logic [255:0] row_data,
    output logic         busy,
    output logic         done,
    output logic [6:0]   rows_written,
    input  logic         en_a,
    input  logic [3:0]   we_a,
    input  logic [8:0]   addr_a,
    input  logic [31:0]  din_a,
    output logic [31:0]  dout_a
);

    localparam int PTR_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LANE_W = 3;
    localparam int WORDS  = ROWS * LANES;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic               row_ready_q;
    logic               row_ready_d;
    logic               busy_q;
    logic               busy_d;
    logic               done_q;
    logic               done_d;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [6:0]         rows_q;
    logic [6:0]         rows_d;
    logic [31:0]        dout_q;
    logic [31:0]        dout_d;

    // Lane-banked storage. There is no reset: only control state is cleared.
    logic [31:0]        mem_q [LANES][ROWS];

    logic               pl_we_s;
    logic               last_row_s;
    logic               ps_rd_s;
    logic               addr_hit_s;
    logic [LANE_W-1:0]  ps_lane_s;
    logic [PTR_W-1:0]   ps_row_s;

    // The PS address splits into a lane (low 3 bits) and a row index.
    assign ps_lane_s = addr_a[LANE_W-1:0];
    assign ps_row_s  = addr_a[LANE_W +: PTR_W];

    // Addresses beyond the buffer read as zero. When the buffer fills the
    // whole 9-bit address space, every address is a hit.
    generate
        if (WORDS >= 512) begin : g_addr_full
            assign addr_hit_s = 1'b1;
        end else begin : g_addr_part
            assign addr_hit_s = ({1'b0, addr_a} < 10'(WORDS));
        end
    endgenerate

    // A start in the same cycle as a handshake drops that row. The restart
    // takes priority over storing it.
    assign pl_we_s    = (state_q == ST_COLLECT) & row_valid & ~start;
    assign last_row_s = (wr_ptr_q == PTR_W'(ROWS - 1));

`ifdef OUTPUT_MEM_PS_WRITE_EN
    logic ps_we_s;
    // A PS cycle with any byte enable set is a write; otherwise it is a read.
    assign ps_we_s = en_a & (we_a != 4'd0) & addr_hit_s;
    assign ps_rd_s = en_a & (we_a == 4'd0);
`else
    logic unused_ps_wr_s;
    assign ps_rd_s        = en_a;
    assign unused_ps_wr_s = ^{we_a, din_a};
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. A start pulse always (re)enters COLLECT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (start) begin
                    state_d = ST_COLLECT;
                end else if (row_valid && last_row_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM output decode. It is taken from the next state, so the registered
    // flags track the state register exactly, with no extra cycle of delay.
    always_comb begin
        row_ready_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_d)
            ST_IDLE: begin
                row_ready_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
            ST_COLLECT: begin
                row_ready_d = 1'b1;
                busy_d      = 1'b1;
                done_d      = 1'b0;
            end
            ST_DONE: begin
                row_ready_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
            default: begin
                row_ready_d = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b0;
            end
        endcase
    end

    // Registered FSM outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            row_ready_q <= row_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Write pointer and row count. The pointer wraps after the last row,
    // while the count saturates at ROWS because the FSM leaves COLLECT.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rows_d   = rows_q;
        if (start) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rows_d   = 7'd0;
        end else if (pl_we_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            rows_d   = rows_q + 7'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
            rows_d   = rows_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rows_q   <= 7'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rows_q   <= rows_d;
        end
    end

    // Memory write port. The PL write comes last, so it overrides a PS
    // write to the same word in the same cycle.
    always_ff @(posedge clk) begin
`ifdef OUTPUT_MEM_PS_WRITE_EN
        if (ps_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (we_a[b]) begin
                    mem_q[ps_lane_s][ps_row_s][8*b +: 8] <= din_a[8*b +: 8];
                end
            end
        end
`endif
        if (pl_we_s) begin
            for (int k = 0; k < LANES; k++) begin
                mem_q[k][wr_ptr_q] <= row_data[(LANES-1-k)*32 +: 32];
            end
        end
    end

    // PS read mux. The array is sampled before this edge's writes land,
    // which gives read-first behaviour on a collision.
    always_comb begin
        dout_d = dout_q;
        if (ps_rd_s) begin
            if (addr_hit_s) begin
                dout_d = mem_q[ps_lane_s][ps_row_s];
            end else begin
                dout_d = 32'd0;
            end
        end else begin
            dout_d = dout_q;
        end
    end

    // PS read data register. It holds when idle and on PS writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 32'd0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign row_ready    = row_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign rows_written = rows_q;
    assign dout_a       = dout_q;

endmodule
